// File: rtl/speed_msg_formatter.sv
// speed_msg_formatter: converts a 16-bit speed to decimal (double-dabble) and streams "V=<digits>\r\n" to a UART transmitter
module speed_msg_formatter #(
  parameter logic [7:0] PREFIX0   = 8'h56,
  parameter logic [7:0] PREFIX1   = 8'h3D,
  parameter bit         SEND_CRLF = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_speed,
  output logic        o_busy,
  output logic        o_drop,
  output logic        o_msg_done,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  input  logic        i_tx_active
);
  typedef enum logic [2:0] {IDLE, CONV, SEL, START, WAIT} state_t;
  state_t state, state_nx;
  logic [15:0] bin;
  logic [19:0] bcd, adj;
  logic [3:0]  cnt, idx, idx_nx, first, dig;
  logic [7:0]  byte_nx;
  logic        last, accept;
  for (genvar d = 0; d < 5; d++) begin : g_adj
    assign adj[d*4 +: 4] = bcd[d*4 +: 4] >= 4'd5 ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
  end
  // byte index: 0,1 prefix; 2..6 digits (ten-thousands..ones); 7,8 CR/LF
  always_comb begin
    first   = bcd[19:16] != 4'd0 ? 4'd2 : bcd[15:12] != 4'd0 ? 4'd3 :
              bcd[11:8]  != 4'd0 ? 4'd4 : bcd[7:4]   != 4'd0 ? 4'd5 : 4'd6;
    dig     = idx == 4'd2 ? bcd[19:16] : idx == 4'd3 ? bcd[15:12] :
              idx == 4'd4 ? bcd[11:8]  : idx == 4'd5 ? bcd[7:4]   : bcd[3:0];
    byte_nx = idx == 4'd0 ? PREFIX0 : idx == 4'd1 ? PREFIX1 :
              idx == 4'd7 ? 8'h0D   : idx == 4'd8 ? 8'h0A   : {4'h3, dig};
    last    = idx == (SEND_CRLF ? 4'd8 : 4'd6);
    idx_nx  = idx == 4'd1 ? first : idx + 4'd1;
    accept  = state == IDLE && i_valid && !o_msg_done;
  end
  always_ff @(posedge i_clock or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? CONV : IDLE;
      CONV:    state_nx = cnt == 4'd15 ? SEL : CONV;
      SEL:     state_nx = START;
      START:   state_nx = i_tx_active ? START : WAIT;
      WAIT:    state_nx = !i_tx_done ? WAIT : last ? IDLE : SEL;
      default: state_nx = IDLE;
    endcase
  end
  // o_msg_done keeps the block busy one extra cycle so a coincident i_valid is dropped
  always_comb begin
    o_busy     = state != IDLE || o_msg_done;
    o_drop     = i_valid && o_busy;
    o_tx_start = state == START && !i_tx_active;
  end
  always_ff @(posedge i_clock or negedge i_rst_n)
    if (!i_rst_n) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      idx        <= '0;
      o_tx_data  <= '0;
      o_msg_done <= 1'b0;
    end else begin
      o_msg_done <= state == WAIT && i_tx_done && last;
      if (accept) begin
        bin <= i_speed;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == CONV) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt        <= cnt + 4'd1;
        idx        <= '0;
      end
      if (state == SEL) o_tx_data <= byte_nx;
      if (state == WAIT && i_tx_done && !last) idx <= idx_nx;
    end
endmodule

// File: tb/tb_speed_msg_formatter.sv
// tb_speed_msg_formatter: directed checks of message content, timing, drops, transmitter backpressure and reset
module tb_speed_msg_formatter;
  logic clk = 0, rst_n = 0, valid = 0, valid0 = 0, active = 0, done = 0, done0 = 0;
  logic [15:0] speed = 0;
  logic busy, drop, md, start, busy0, drop0, md0, start0;
  logic [7:0] data, data0;
  int cyc, pass, total, lat = 3, cnt, cnt0, starts, fs_cyc, md_cnt, vcyc;
  bit prev_start;
  logic [7:0] q[$], q0[$];

  speed_msg_formatter dut (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid), .i_speed(speed),
    .o_busy(busy), .o_drop(drop), .o_msg_done(md), .o_tx_start(start),
    .o_tx_data(data), .i_tx_done(done), .i_tx_active(active));

  speed_msg_formatter #(.SEND_CRLF(1'b0)) dut0 (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid0), .i_speed(speed),
    .o_busy(busy0), .o_drop(drop0), .o_msg_done(md0), .o_tx_start(start0),
    .o_tx_data(data0), .i_tx_done(done0), .i_tx_active(1'b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // transmitter model: captures bytes on start, pulses done after lat cycles
  always @(negedge clk) begin
    done = 0;
    if (!rst_n) cnt = 0;
    if (md) md_cnt++;
    if (start) begin
      total++;
      if (prev_start || cnt > 0) $display("FAIL start_spacing got prev=%0d pending=%0d want 0/0", prev_start, cnt);
      else pass++;
      q.push_back(data);
      starts++;
      if (starts == 1) fs_cyc = cyc;
      cnt = lat;
    end else if (cnt > 0) begin
      total++;
      if (data !== q[$]) $display("FAIL tx_data_stable got %h want %h", data, q[$]);
      else pass++;
      cnt--;
      if (cnt == 0) done = 1;
    end
    prev_start = start;
  end

  always @(negedge clk) begin
    done0 = 0;
    if (!rst_n) cnt0 = 0;
    if (start0) begin
      q0.push_back(data0);
      cnt0 = 3;
    end else if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) done0 = 1;
    end
  end

  task automatic send(input logic [15:0] s);
    @(posedge clk); #1 valid = 1; speed = s; vcyc = cyc;
    @(posedge clk); #1 valid = 0;
  endtask

  task automatic wait_msg(input int budget);
    int m;
    m = md_cnt;
    for (int i = 0; i < budget && md_cnt == m; i++) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 total++;
    if ({busy, drop, md, start, data} !== 12'h0) $display("FAIL reset_outputs got %h want 000", {busy, drop, md, start, data});
    else pass++;
    rst_n = 1;
    @(posedge clk);
  endtask

  task automatic test_zero;
    int m;
    logic [71:0] e;
    e = 72'h563D300D0A; lat = 20; q.delete(); starts = 0; m = md_cnt;
    send(0);
    wait_msg(400);
    total++;
    if (md_cnt !== m + 1) $display("FAIL zero_msg_done got %0d want %0d", md_cnt - m, 1); else pass++;
    @(negedge clk) total++;
    if (busy !== 1'b0) $display("FAIL zero_busy_after got %b want 0", busy); else pass++;
    total++;
    if (q.size() != 5) $display("FAIL zero_len got %0d want 5", q.size()); else pass++;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(4-i)*8 +: 8]) $display("FAIL zero_byte%0d got %h want %h", i, q[i], e[(4-i)*8 +: 8]); else pass++;
    end
    repeat (30) @(posedge clk);
    total++;
    if (md_cnt !== m + 1) $display("FAIL zero_msg_done_once got %0d want 1", md_cnt - m); else pass++;
  endtask

  task automatic test_max;
    int m;
    logic [71:0] e;
    e = 72'h563D36353533350D0A; lat = 3; q.delete(); starts = 0; m = md_cnt;
    send(16'hFFFF);
    wait_msg(200);
    total++;
    if (md_cnt !== m + 1) $display("FAIL max_msg_done got %0d want 1", md_cnt - m); else pass++;
    total++;
    if (fs_cyc - vcyc != 18) $display("FAIL max_first_start_latency got %0d want 18", fs_cyc - vcyc); else pass++;
    total++;
    if (q.size() != 9) $display("FAIL max_len got %0d want 9", q.size()); else pass++;
    for (int i = 0; i < 9 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(8-i)*8 +: 8]) $display("FAIL max_byte%0d got %h want %h", i, q[i], e[(8-i)*8 +: 8]); else pass++;
    end
  endtask

  task automatic test_nocrlf;
    logic [71:0] e;
    e = 72'h563D31303035; q0.delete();
    @(posedge clk); #1 valid0 = 1; speed = 16'd1005;
    @(posedge clk); #1 valid0 = 0;
    for (int i = 0; i < 200 && (q0.size() < 6 || busy0); i++) @(posedge clk);
    repeat (20) @(posedge clk);
    total++;
    if (q0.size() != 6) $display("FAIL nocrlf_len got %0d want 6", q0.size()); else pass++;
    for (int i = 0; i < 6 && i < q0.size(); i++) begin
      total++;
      if (q0[i] !== e[(5-i)*8 +: 8]) $display("FAIL nocrlf_byte%0d got %h want %h", i, q0[i], e[(5-i)*8 +: 8]); else pass++;
    end
  endtask

  task automatic test_drop;
    int m;
    logic [71:0] e;
    e = 72'h563D3235300D0A; lat = 5; q.delete(); starts = 0;
    send(16'd250);
    repeat (3) @(posedge clk);
    #1 valid = 1; speed = 16'd7;
    @(negedge clk) total++;
    if (drop !== 1'b1) $display("FAIL drop_conv got %b want 1", drop); else pass++;
    @(posedge clk); #1 valid = 0;
    for (int i = 0; i < 100 && cnt == 0; i++) @(posedge clk);
    #1 valid = 1; speed = 16'd7;
    @(negedge clk) total++;
    if (drop !== 1'b1) $display("FAIL drop_wait got %b want 1", drop); else pass++;
    @(posedge clk); #1 valid = 0;
    for (int i = 0; i < 300 && md !== 1'b1; i++) begin @(posedge clk); #1; end
    total++;
    if (md !== 1'b1) $display("FAIL drop_msg_done got %b want 1", md); else pass++;
    total++;
    if (q.size() != 7) $display("FAIL drop_len got %0d want 7", q.size()); else pass++;
    for (int i = 0; i < 7 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(6-i)*8 +: 8]) $display("FAIL drop_byte%0d got %h want %h", i, q[i], e[(6-i)*8 +: 8]); else pass++;
    end
    q.delete();
    valid = 1; speed = 16'd7;
    @(negedge clk) total++;
    if ({drop, busy} !== 2'b11) $display("FAIL drop_at_msg_done got %b want 11", {drop, busy}); else pass++;
    @(posedge clk); #1;
    @(negedge clk) total++;
    if (drop !== 1'b0) $display("FAIL accept_after_done got drop=%b want 0", drop); else pass++;
    m = md_cnt;
    @(posedge clk); #1 valid = 0;
    wait_msg(200);
    e = 72'h563D370D0A;
    total++;
    if (md_cnt !== m + 1) $display("FAIL seven_msg_done got %0d want 1", md_cnt - m); else pass++;
    total++;
    if (q.size() != 5) $display("FAIL seven_len got %0d want 5", q.size()); else pass++;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(4-i)*8 +: 8]) $display("FAIL seven_byte%0d got %h want %h", i, q[i], e[(4-i)*8 +: 8]); else pass++;
    end
  endtask

  task automatic test_active;
    int r;
    logic [71:0] e;
    e = 72'h563D39390D0A; lat = 3; q.delete(); starts = 0; active = 1;
    send(16'd99);
    repeat (66) @(posedge clk);
    #1 total++;
    if (starts != 0) $display("FAIL active_hold_start got %0d want 0", starts); else pass++;
    total++;
    if ({busy, data} !== 9'h156) $display("FAIL active_hold_data got %h want 156", {busy, data}); else pass++;
    active = 0; r = cyc;
    wait_msg(200);
    total++;
    if (fs_cyc != r) $display("FAIL active_release_start got %0d want %0d", fs_cyc - r, 0); else pass++;
    total++;
    if (q.size() != 6) $display("FAIL active_len got %0d want 6", q.size()); else pass++;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(5-i)*8 +: 8]) $display("FAIL active_byte%0d got %h want %h", i, q[i], e[(5-i)*8 +: 8]); else pass++;
    end
  endtask

  task automatic test_reset_mid;
    int m;
    logic [71:0] e;
    e = 72'h563D34320D0A; lat = 10; q.delete(); starts = 0;
    send(16'd123);
    for (int i = 0; i < 300 && starts < 3; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1 total++;
    if ({starts == 3, busy} !== 2'b11) $display("FAIL mid_in_wait got starts=%0d busy=%b want 3/1", starts, busy); else pass++;
    #2 rst_n = 0;
    #1 total++;
    if ({busy, drop, md, start, data} !== 12'h0) $display("FAIL mid_reset_outputs got %h want 000", {busy, drop, md, start, data}); else pass++;
    repeat (5) @(posedge clk);
    #1 rst_n = 1;
    repeat (40) @(posedge clk);
    #1 total++;
    if ({starts, busy} !== {32'd3, 1'b0}) $display("FAIL mid_no_resume got starts=%0d busy=%b want 3/0", starts, busy); else pass++;
    q.delete(); m = md_cnt;
    send(16'd42);
    wait_msg(300);
    total++;
    if (md_cnt !== m + 1) $display("FAIL mid_new_msg_done got %0d want 1", md_cnt - m); else pass++;
    total++;
    if (q.size() != 6) $display("FAIL mid_len got %0d want 6", q.size()); else pass++;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      total++;
      if (q[i] !== e[(5-i)*8 +: 8]) $display("FAIL mid_byte%0d got %h want %h", i, q[i], e[(5-i)*8 +: 8]); else pass++;
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_max;
    test_nocrlf;
    test_drop;
    test_active;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
